// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat hand-level sequencer.
//   round_state_t : sequencer state encoding
//   ERR_TIMEOUT   : err_code bit set when a hand never reaches halt
//   ERR_NOLIGHT   : err_code bit set when halt arrives with neither light on
package baccarat_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET_HAND,
        PLAY,
        TALLY,
        HOLD
    } round_state_t;

    localparam int unsigned ERR_TIMEOUT = 0;
    localparam int unsigned ERR_NOLIGHT = 1;

    // Largest of three values; sizes the shared phase counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/baccarat_round_ctrl_if.sv
// Board-side bundle of the hand sequencer.
//   master : board/statemachine side (drives controls and statemachine status)
//   slave  : baccarat_round_ctrl (drives hand_resetb, status and tallies)
interface baccarat_round_ctrl_if #(
    parameter int unsigned WIN_W = 8
);
    logic             start;
    logic             auto_play;
    logic             clear;
    logic             halt;
    logic             player_win_light;
    logic             dealer_win_light;
    logic             hand_resetb;
    logic             busy;
    logic             result_valid;
    logic [WIN_W-1:0] hand_count;
    logic [WIN_W-1:0] player_wins;
    logic [WIN_W-1:0] dealer_wins;
    logic [WIN_W-1:0] ties;
    logic [1:0]       err_code;

    modport master (
        output start, auto_play, clear, halt, player_win_light, dealer_win_light,
        input  hand_resetb, busy, result_valid, hand_count, player_wins, dealer_wins,
               ties, err_code
    );

    modport slave (
        input  start, auto_play, clear, halt, player_win_light, dealer_win_light,
        output hand_resetb, busy, result_valid, hand_count, player_wins, dealer_wins,
               ties, err_code
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; clr has priority over inc.
//   slow_clock, resetb : clock, async active-low reset
//   clr                : synchronous clear to zero
//   inc                : increment by one unless already at all-ones
//   q                  : count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         slow_clock,
    input  logic         resetb,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    localparam logic [W-1:0] Q_MAX = '1;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != Q_MAX)) begin
            q <= q + W'(1);
        end
    end
endmodule

// File: rtl/baccarat_round_ctrl.sv
// Hand-level sequencer: owns hand_resetb of the dealing statemachine, starts hands,
// tallies results, holds them on the lights and retries hands that never halt.
//   slow_clock, resetb : clock, async active-low reset
//   bus (slave)        : start/auto_play/clear controls, halt and result lights in;
//                        hand_resetb, busy, result_valid, tallies and err_code out
module baccarat_round_ctrl
    import baccarat_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned WIN_W       = 8,
    parameter int unsigned MAX_HANDS   = 0
) (
    input  logic                  slow_clock,
    input  logic                  resetb,
    baccarat_round_ctrl_if.slave  bus
);
    localparam int unsigned PH_MAX = max3(RST_CYCLES, HOLD_CYCLES, TIMEOUT);
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0] PH_ONE      = PH_W'(1);
    localparam logic [PH_W-1:0] RST_LAST    = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0] HOLD_END    = PH_W'(HOLD_CYCLES);
    localparam logic [PH_W-1:0] TIMEOUT_END = PH_W'(TIMEOUT);

    // A session limit beyond the counter range is reached when hand_count saturates.
    localparam longint unsigned SAT_MAX   = (64'd1 << WIN_W) - 64'd1;
    localparam longint unsigned LIMIT     = (64'(MAX_HANDS) > SAT_MAX) ? SAT_MAX
                                                                       : 64'(MAX_HANDS);
    localparam logic [WIN_W-1:0] LIMIT_Q  = WIN_W'(LIMIT);
    localparam bit               LIMIT_EN = (MAX_HANDS != 0);

    round_state_t     state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [1:0]       err_q, err_set_c;
    logic             hand_resetb_q, busy_q, result_valid_q;
    logic             timeout_c, tally_c, limit_hit_c;
    logic [WIN_W-1:0] hand_count_q, player_wins_q, dealer_wins_q, ties_q;

    assign tally_c     = (state_q == TALLY);
    assign limit_hit_c = LIMIT_EN && (hand_count_q == LIMIT_Q);

    // Next state and shared phase counter (reset length, play length, hold length).
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        timeout_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RESET_HAND;
                    phase_d = '0;
                end
            end
            RESET_HAND: begin
                if (phase_q == RST_LAST) begin
                    state_d = PLAY;
                    phase_d = PH_ONE;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            PLAY: begin
                if (bus.halt) begin
                    state_d = TALLY;
                end else if (phase_q == TIMEOUT_END) begin
                    timeout_c = 1'b1;
                    state_d   = RESET_HAND;
                    phase_d   = '0;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            TALLY: begin
                state_d = HOLD;
                phase_d = PH_ONE;
            end
            HOLD: begin
                if (phase_q == HOLD_END) begin
                    if (limit_hit_c) begin
                        state_d = IDLE;
                    end else if (bus.auto_play || bus.start) begin
                        state_d = RESET_HAND;
                        phase_d = '0;
                    end
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Sticky error bits; clear wins over a same-cycle set.
    always_comb begin
        err_set_c              = '0;
        err_set_c[ERR_TIMEOUT] = timeout_c;
        err_set_c[ERR_NOLIGHT] = tally_c && !bus.player_win_light && !bus.dealer_win_light;
    end

    // State, phase and registered status outputs (decoded from the next state).
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q        <= IDLE;
            phase_q        <= '0;
            err_q          <= '0;
            hand_resetb_q  <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            err_q          <= bus.clear ? 2'b00 : (err_q | err_set_c);
            hand_resetb_q  <= state_d inside {PLAY, TALLY, HOLD};
            busy_q         <= state_d inside {RESET_HAND, PLAY, TALLY};
            result_valid_q <= (state_d == TALLY);
        end
    end

    sat_counter #(.W(WIN_W)) u_hand_count (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .clr        (bus.clear),
        .inc        (tally_c),
        .q          (hand_count_q)
    );

    sat_counter #(.W(WIN_W)) u_player_wins (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .clr        (bus.clear),
        .inc        (tally_c && bus.player_win_light && !bus.dealer_win_light),
        .q          (player_wins_q)
    );

    sat_counter #(.W(WIN_W)) u_dealer_wins (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .clr        (bus.clear),
        .inc        (tally_c && !bus.player_win_light && bus.dealer_win_light),
        .q          (dealer_wins_q)
    );

    sat_counter #(.W(WIN_W)) u_ties (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .clr        (bus.clear),
        .inc        (tally_c && bus.player_win_light && bus.dealer_win_light),
        .q          (ties_q)
    );

    assign bus.hand_resetb  = hand_resetb_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.hand_count   = hand_count_q;
    assign bus.player_wins  = player_wins_q;
    assign bus.dealer_wins  = dealer_wins_q;
    assign bus.ties         = ties_q;
    assign bus.err_code     = err_q;
endmodule
